commit_scheduler: RTL and testbench
===================================

# commit_scheduler

Sequences retired ROB results into the register file's single commit port, and orders misbranch recovery behind the commits. The ROB can retire up to two entries per cycle into a small in-order queue. The scheduler drains that queue one entry per cycle into `registers`. On a misbranch it stops accepting retirements, drains every queued commit, and only then pulses the register file's misbranch input.

## Interface
Parameters:
- `QUEUE_DEPTH`, default 4: commit queue entries; must be a power of two and at least 2.
- `DATA_W`, default 32: commit value width.
- `REG_W`, default 5: architectural register tag width.
- `ROB_W`, default 4: ROB tag width, same as `ROB_TAG_WIDTH`.

Ports (name, direction, width, meaning):
- `clk` in 1: the single clock.
- `rst` in 1: reset, asynchronous and active-low.
- `rdy` in 1: global ready. When low, all state and outputs hold.
- `in_rob_commit_valid` in 2: per-lane retire valid. Lane 0 is older than lane 1.
- `in_rob_commit_reg0`, `in_rob_commit_reg1` in `REG_W`: destination register per lane.
- `in_rob_commit_rob0`, `in_rob_commit_rob1` in `ROB_W`: ROB tag per lane.
- `in_rob_commit_value0`, `in_rob_commit_value1` in `DATA_W`: result value per lane.
- `out_rob_commit_ready` out 1: both lanes are accepted this cycle.
- `in_rob_misbranch` in 1: one-cycle misbranch request.
- `out_reg_commit_reg` out `REG_W`: register file commit port; 0 means no write.
- `out_reg_commit_rob` out `ROB_W`: register file commit port ROB tag.
- `out_reg_commit_value` out `DATA_W`: register file commit port value.
- `out_reg_misbranch` out 1: misbranch pulse to the register file.
- `out_flush_busy` out 1: recovery in progress. The fetcher must keep `in_fetcher_ce` low while this is high.
- `out_queue_count` out `clog2(QUEUE_DEPTH)+1`: current queue occupancy.

## Operation
- FSM states: RUN, DRAIN, SIGNAL.
- `out_rob_commit_ready` = `rdy` && state == RUN && count <= `QUEUE_DEPTH`-2. It is computed from the current count and ignores any same-cycle pop.
- Enqueue, on a rising edge with `rdy` and `out_rob_commit_ready` high:
  - Valid lanes are pushed in the order lane 0, then lane 1.
  - A lane with reg == 0 is dropped and takes no slot.
  - A lane-1-only valid is legal.
- Dequeue, on every rising edge with `rdy` high:
  - If count > 0 at cycle start, pop the head into the `out_reg_commit_*` registers.
  - Otherwise load `out_reg_commit_reg` = 0; rob and value are don't-care, driven 0.
  - A pop and pushes in the same edge are both applied. Count changes by pushes − pop.
- Pointers are `clog2(QUEUE_DEPTH)` bits and wrap modulo `QUEUE_DEPTH`.
- Transitions:
  - RUN → DRAIN on an edge where `in_rob_misbranch` is high. That edge's commits are still accepted, because they are older than the branch.
  - DRAIN → SIGNAL on an edge where count == 0 at cycle start.
  - SIGNAL → RUN unconditionally.
- The ROB asserts `in_rob_misbranch` only while `out_rob_commit_ready` is high; this is a protocol rule. `in_rob_misbranch` is ignored outside RUN.
- `out_reg_misbranch` is registered. It is 1 only during the cycle after the DRAIN → SIGNAL edge, and `out_reg_commit_reg` = 0 in that cycle.
- `out_flush_busy` = state != RUN.

## Timing
- Reset (`rst` = 0, asynchronous):
  - state = RUN, pointers = 0, count = 0.
  - `out_reg_commit_reg`/`rob`/`value` = 0.
  - `out_reg_misbranch` = 0, `out_flush_busy` = 0, `out_queue_count` = 0.
  - `out_rob_commit_ready` is low while in reset and high afterwards when `rdy` is high.
  - Reset mid-drain discards all queued commits.
- Latency: an entry accepted at edge N into an empty queue is on `out_reg_commit_*` after edge N+1, and the register file writes it at edge N+2.
- Throughput: one commit per cycle out; up to two per cycle in while count <= `QUEUE_DEPTH`-2.
- Misbranch sampled at edge E with k entries after E's pushes:
  - Entries appear after edges E+1 … E+k.
  - State becomes SIGNAL at edge E+k+1, so `out_reg_misbranch` is high during the cycle after edge E+k+1.
  - State returns to RUN at edge E+k+2.
  - With k = 0, `out_reg_misbranch` is high after edge E+1.
- `rdy` low: no push, no pop, no state change, and outputs hold. The held commit is consumed by the register file at the first edge with `rdy` high, so it is never duplicated.

## Structure
- Shared constants file: `DATA_WIDTH`, `REG_TAG_WIDTH`, `ROB_TAG_WIDTH`, TRUE/FALSE, and the encodings for the three FSM states.
- Sub-module `commit_fifo`: a 2-push/1-pop circular buffer with count output, holding {reg, rob, value}.
- The top level holds the FSM, the ready logic, the drop-reg-0 filter and the output registers.

## Test plan
- Single commit: lane 0 with reg 3, rob 5, value 0xDEAD at edge 1. Required: `out_reg_commit_reg` = 3 after edge 2, then 0 after edge 3; count returns to 0.
- Dual retire and backpressure: both lanes every cycle with `QUEUE_DEPTH` 4. Required: ready drops when count reaches 3; outputs keep strict lane-0-before-lane-1 order; pointers wrap with no loss over 20 commits.
- Reg 0 filter: lane 0 reg 0 and lane 1 reg 7. Required: only reg 7 is enqueued, count is 1.
- Misbranch with 3 queued:
  - Required: ready = 0 and `out_flush_busy` = 1 from the next cycle.
  - Three commits come out in order, then one cycle with `out_reg_misbranch` = 1 and reg = 0.
  - Then RUN and ready = 1.
- Misbranch with an empty queue: `out_reg_misbranch` is high the cycle after edge E+1, and `out_flush_busy` clears after edge E+2.
- `rdy` held low for 3 cycles mid-drain: outputs and count are frozen. Then `rst` is pulsed low mid-drain: all outputs are 0 asynchronously and state is RUN.

Source files
------------

// File: rtl/commit_scheduler_pkg.sv
// rtl/commit_scheduler_pkg.sv - shared widths, flags and FSM encodings for the commit scheduler
package commit_scheduler_pkg;

    localparam int DATA_WIDTH    = 32;
    localparam int REG_TAG_WIDTH = 5;
    localparam int ROB_TAG_WIDTH = 4;

    localparam logic TRUE  = 1'b1;
    localparam logic FALSE = 1'b0;

    typedef enum logic [1:0] {
        ST_RUN    = 2'd0,
        ST_DRAIN  = 2'd1,
        ST_SIGNAL = 2'd2
    } state_t;

endpackage

// File: rtl/commit_fifo.sv
// rtl/commit_fifo.sv - two-push one-pop circular buffer of {reg, rob, value} commit entries
module commit_fifo #(
    parameter int DEPTH   = 4,
    parameter int ENTRY_W = 41
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push0,
    input  logic [ENTRY_W-1:0]       data0,
    input  logic                     push1,
    input  logic [ENTRY_W-1:0]       data1,
    input  logic                     pop,
    output logic [ENTRY_W-1:0]       head,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [ENTRY_W-1:0] mem [DEPTH];
    logic [PTR_W-1:0]   wr_ptr;
    logic [PTR_W-1:0]   rd_ptr;
    logic [PTR_W-1:0]   wr_ptr_inc;
    logic [PTR_W-1:0]   lane1_slot;

    assign wr_ptr_inc = wr_ptr + PTR_W'(1);
    // Lane 1 lands behind lane 0 when both push, otherwise it takes the next free slot.
    assign lane1_slot = push0 ? wr_ptr_inc : wr_ptr;
    assign head       = mem[rd_ptr];

    // Entry storage; the caller never pushes more than the free space allows.
    always_ff @(posedge clk) begin
        if (push0) begin
            mem[wr_ptr] <= data0;
        end
        if (push1) begin
            mem[lane1_slot] <= data1;
        end
    end

    // Pointers wrap modulo DEPTH; count tracks pushes minus pop in the same edge.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            wr_ptr <= wr_ptr + PTR_W'(push0) + PTR_W'(push1);
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            count <= count + CNT_W'(push0) + CNT_W'(push1) - CNT_W'(pop);
        end
    end

endmodule

// File: rtl/commit_scheduler.sv
// rtl/commit_scheduler.sv - serialises retired ROB results onto the register commit port and orders misbranch recovery
module commit_scheduler
    import commit_scheduler_pkg::*;
#(
    parameter int QUEUE_DEPTH = 4,
    parameter int DATA_W      = DATA_WIDTH,
    parameter int REG_W       = REG_TAG_WIDTH,
    parameter int ROB_W       = ROB_TAG_WIDTH
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           rdy,
    input  logic [1:0]                     in_rob_commit_valid,
    input  logic [REG_W-1:0]               in_rob_commit_reg0,
    input  logic [REG_W-1:0]               in_rob_commit_reg1,
    input  logic [ROB_W-1:0]               in_rob_commit_rob0,
    input  logic [ROB_W-1:0]               in_rob_commit_rob1,
    input  logic [DATA_W-1:0]              in_rob_commit_value0,
    input  logic [DATA_W-1:0]              in_rob_commit_value1,
    output logic                           out_rob_commit_ready,
    input  logic                           in_rob_misbranch,
    output logic [REG_W-1:0]               out_reg_commit_reg,
    output logic [ROB_W-1:0]               out_reg_commit_rob,
    output logic [DATA_W-1:0]              out_reg_commit_value,
    output logic                           out_reg_misbranch,
    output logic                           out_flush_busy,
    output logic [$clog2(QUEUE_DEPTH):0]   out_queue_count
);

    localparam int CNT_W   = $clog2(QUEUE_DEPTH) + 1;
    localparam int ENTRY_W = REG_W + ROB_W + DATA_W;

    state_t             state;
    state_t             state_next;
    logic [CNT_W-1:0]   count;
    logic [ENTRY_W-1:0] head;
    logic               queue_empty;
    logic               accept;
    logic               push0;
    logic               push1;
    logic               pop;

    assign queue_empty = (count == '0);
    // Two free slots are required so both lanes can always land; any same-cycle pop is ignored.
    assign accept = rdy && (state == ST_RUN) && (count <= CNT_W'(QUEUE_DEPTH - 2));
    assign out_rob_commit_ready = accept && rst;

    // Register 0 is the "no write" tag, so such lanes never occupy a slot.
    assign push0 = accept && in_rob_commit_valid[0] && (in_rob_commit_reg0 != '0);
    assign push1 = accept && in_rob_commit_valid[1] && (in_rob_commit_reg1 != '0);
    assign pop   = rdy && !queue_empty;

    assign out_flush_busy  = (state != ST_RUN);
    assign out_queue_count = count;

    commit_fifo #(
        .DEPTH   (QUEUE_DEPTH),
        .ENTRY_W (ENTRY_W)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push0 (push0),
        .data0 ({in_rob_commit_reg0, in_rob_commit_rob0, in_rob_commit_value0}),
        .push1 (push1),
        .data1 ({in_rob_commit_reg1, in_rob_commit_rob1, in_rob_commit_value1}),
        .pop   (pop),
        .head  (head),
        .count (count)
    );

    // State register; a low rdy freezes recovery progress.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= ST_RUN;
        end else if (rdy) begin
            state <= state_next;
        end
    end

    // Recovery sequencing: stop intake, empty the queue, then one signalling cycle.
    always_comb begin
        state_next = state;
        case (state)
            ST_RUN:    if (in_rob_misbranch) state_next = ST_DRAIN;
            ST_DRAIN:  if (queue_empty) state_next = ST_SIGNAL;
            ST_SIGNAL: state_next = ST_RUN;
            default:   state_next = ST_RUN;
        endcase
    end

    // Commit port and misbranch pulse; held while rdy is low so nothing is written twice.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            out_reg_commit_reg   <= '0;
            out_reg_commit_rob   <= '0;
            out_reg_commit_value <= '0;
            out_reg_misbranch    <= FALSE;
        end else if (rdy) begin
            if (pop) begin
                {out_reg_commit_reg, out_reg_commit_rob, out_reg_commit_value} <= head;
            end else begin
                out_reg_commit_reg   <= '0;
                out_reg_commit_rob   <= '0;
                out_reg_commit_value <= '0;
            end
            out_reg_misbranch <= (state == ST_DRAIN && queue_empty) ? TRUE : FALSE;
        end
    end

endmodule

// File: tb/tb_commit_scheduler.sv
// tb/tb_commit_scheduler.sv - self-checking bench for commit_scheduler
module tb_commit_scheduler;

    logic        clk;
    logic        rst;
    logic        rdy;
    logic [1:0]  in_rob_commit_valid;
    logic [4:0]  in_rob_commit_reg0;
    logic [4:0]  in_rob_commit_reg1;
    logic [3:0]  in_rob_commit_rob0;
    logic [3:0]  in_rob_commit_rob1;
    logic [31:0] in_rob_commit_value0;
    logic [31:0] in_rob_commit_value1;
    logic        out_rob_commit_ready;
    logic        in_rob_misbranch;
    logic [4:0]  out_reg_commit_reg;
    logic [3:0]  out_reg_commit_rob;
    logic [31:0] out_reg_commit_value;
    logic        out_reg_misbranch;
    logic        out_flush_busy;
    logic [2:0]  out_queue_count;

    commit_scheduler dut (
        .clk                  (clk),
        .rst                  (rst),
        .rdy                  (rdy),
        .in_rob_commit_valid  (in_rob_commit_valid),
        .in_rob_commit_reg0   (in_rob_commit_reg0),
        .in_rob_commit_reg1   (in_rob_commit_reg1),
        .in_rob_commit_rob0   (in_rob_commit_rob0),
        .in_rob_commit_rob1   (in_rob_commit_rob1),
        .in_rob_commit_value0 (in_rob_commit_value0),
        .in_rob_commit_value1 (in_rob_commit_value1),
        .out_rob_commit_ready (out_rob_commit_ready),
        .in_rob_misbranch     (in_rob_misbranch),
        .out_reg_commit_reg   (out_reg_commit_reg),
        .out_reg_commit_rob   (out_reg_commit_rob),
        .out_reg_commit_value (out_reg_commit_value),
        .out_reg_misbranch    (out_reg_misbranch),
        .out_flush_busy       (out_flush_busy),
        .out_queue_count      (out_queue_count)
    );

    typedef struct packed {
        logic [4:0]  r;
        logic [3:0]  rob;
        logic [31:0] v;
    } ent_t;

    typedef struct {
        logic [1:0] valid;
        logic [4:0] reg0;
        logic [4:0] reg1;
        logic       misb;
        logic [4:0] exp_reg;
        logic [2:0] exp_count;
        logic       exp_ready;
        logic       exp_busy;
        logic       exp_misb;
    } vec_t;

    ent_t sb[$];
    int   checks = 0;
    int   errors = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic drive(input logic [1:0] v, input logic [4:0] r0, input logic [4:0] r1, input logic m);
        in_rob_commit_valid  = v;
        in_rob_commit_reg0   = r0;
        in_rob_commit_reg1   = r1;
        in_rob_commit_rob0   = 4'(r0 + 5'd2);
        in_rob_commit_rob1   = 4'(r1 + 5'd2);
        in_rob_commit_value0 = 32'hDEAA + 32'(r0);
        in_rob_commit_value1 = 32'hDEAA + 32'(r1);
        in_rob_misbranch     = m;
    endtask

    // One clock: record accepted lanes, advance, then score any commit the DUT presents.
    task automatic step();
        logic was_rdy;
        logic acc;
        ent_t e;
        ent_t got;
        was_rdy = rdy;
        acc     = out_rob_commit_ready;
        if (acc && in_rob_commit_valid[0] && in_rob_commit_reg0 != 5'd0)
            sb.push_back('{in_rob_commit_reg0, in_rob_commit_rob0, in_rob_commit_value0});
        if (acc && in_rob_commit_valid[1] && in_rob_commit_reg1 != 5'd0)
            sb.push_back('{in_rob_commit_reg1, in_rob_commit_rob1, in_rob_commit_value1});
        @(posedge clk);
        #1;
        if (was_rdy && out_reg_commit_reg != 5'd0) begin
            got = '{out_reg_commit_reg, out_reg_commit_rob, out_reg_commit_value};
            if (sb.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL sb_extra actual=%0h required=none", got);
            end else begin
                e = sb.pop_front();
                check("sb_commit", got, e);
            end
        end
    endtask

    vec_t vecs[17];

    initial begin
        rst = 1'b1;
        rdy = 1'b1;
        drive(2'b00, 5'd0, 5'd0, 1'b0);

        #1 rst = 1'b0;
        #2;
        check("rst_ready", out_rob_commit_ready, 1'b0);
        check("rst_reg", out_reg_commit_reg, 5'd0);
        check("rst_count", out_queue_count, 3'd0);
        check("rst_busy", out_flush_busy, 1'b0);
        check("rst_misb", out_reg_misbranch, 1'b0);
        @(posedge clk);
        #3 rst = 1'b1;
        #1;
        check("post_rst_ready", out_rob_commit_ready, 1'b1);

        //            valid  r0    r1     m     reg   cnt  rdy   busy  misb
        vecs[0]  = '{2'b01, 5'd3, 5'd0,  1'b0, 5'd0,  3'd1, 1'b1, 1'b0, 1'b0};
        vecs[1]  = '{2'b00, 5'd0, 5'd0,  1'b0, 5'd3,  3'd0, 1'b1, 1'b0, 1'b0};
        vecs[2]  = '{2'b00, 5'd0, 5'd0,  1'b0, 5'd0,  3'd0, 1'b1, 1'b0, 1'b0};
        vecs[3]  = '{2'b11, 5'd0, 5'd7,  1'b0, 5'd0,  3'd1, 1'b1, 1'b0, 1'b0};
        vecs[4]  = '{2'b00, 5'd0, 5'd0,  1'b0, 5'd7,  3'd0, 1'b1, 1'b0, 1'b0};
        vecs[5]  = '{2'b11, 5'd1, 5'd2,  1'b0, 5'd0,  3'd2, 1'b1, 1'b0, 1'b0};
        vecs[6]  = '{2'b11, 5'd4, 5'd5,  1'b0, 5'd1,  3'd3, 1'b0, 1'b0, 1'b0};
        vecs[7]  = '{2'b11, 5'd9, 5'd10, 1'b0, 5'd2,  3'd2, 1'b1, 1'b0, 1'b0};
        vecs[8]  = '{2'b11, 5'd6, 5'd12, 1'b1, 5'd4,  3'd3, 1'b0, 1'b1, 1'b0};
        vecs[9]  = '{2'b00, 5'd0, 5'd0,  1'b0, 5'd5,  3'd2, 1'b0, 1'b1, 1'b0};
        vecs[10] = '{2'b00, 5'd0, 5'd0,  1'b0, 5'd6,  3'd1, 1'b0, 1'b1, 1'b0};
        vecs[11] = '{2'b00, 5'd0, 5'd0,  1'b0, 5'd12, 3'd0, 1'b0, 1'b1, 1'b0};
        vecs[12] = '{2'b00, 5'd0, 5'd0,  1'b0, 5'd0,  3'd0, 1'b0, 1'b1, 1'b1};
        vecs[13] = '{2'b00, 5'd0, 5'd0,  1'b0, 5'd0,  3'd0, 1'b1, 1'b0, 1'b0};
        vecs[14] = '{2'b00, 5'd0, 5'd0,  1'b1, 5'd0,  3'd0, 1'b0, 1'b1, 1'b0};
        vecs[15] = '{2'b00, 5'd0, 5'd0,  1'b0, 5'd0,  3'd0, 1'b0, 1'b1, 1'b1};
        vecs[16] = '{2'b00, 5'd0, 5'd0,  1'b0, 5'd0,  3'd0, 1'b1, 1'b0, 1'b0};

        for (int i = 0; i < 17; i++) begin
            drive(vecs[i].valid, vecs[i].reg0, vecs[i].reg1, vecs[i].misb);
            step();
            check($sformatf("row%0d_reg", i), out_reg_commit_reg, vecs[i].exp_reg);
            check($sformatf("row%0d_count", i), out_queue_count, vecs[i].exp_count);
            check($sformatf("row%0d_ready", i), out_rob_commit_ready, vecs[i].exp_ready);
            check($sformatf("row%0d_busy", i), out_flush_busy, vecs[i].exp_busy);
            check($sformatf("row%0d_misb", i), out_reg_misbranch, vecs[i].exp_misb);
        end

        // rdy stalls mid-drain, then an asynchronous reset discards the rest.
        drive(2'b11, 5'd20, 5'd21, 1'b0);
        step();
        check("stall_fill_count", out_queue_count, 3'd2);
        drive(2'b11, 5'd22, 5'd23, 1'b1);
        step();
        check("stall_misb_reg", out_reg_commit_reg, 5'd20);
        check("stall_misb_count", out_queue_count, 3'd3);
        drive(2'b00, 5'd0, 5'd0, 1'b0);
        step();
        check("stall_pre_reg", out_reg_commit_reg, 5'd21);
        rdy = 1'b0;
        for (int i = 0; i < 3; i++) begin
            step();
            check($sformatf("stall%0d_reg", i), out_reg_commit_reg, 5'd21);
            check($sformatf("stall%0d_value", i), out_reg_commit_value, 32'hDEAA + 32'd21);
            check($sformatf("stall%0d_count", i), out_queue_count, 3'd2);
            check($sformatf("stall%0d_busy", i), out_flush_busy, 1'b1);
        end
        rdy = 1'b1;
        step();
        check("resume_reg", out_reg_commit_reg, 5'd22);
        check("resume_count", out_queue_count, 3'd1);
        #2 rst = 1'b0;
        #1;
        check("arst_reg", out_reg_commit_reg, 5'd0);
        check("arst_rob", out_reg_commit_rob, 4'd0);
        check("arst_value", out_reg_commit_value, 32'd0);
        check("arst_count", out_queue_count, 3'd0);
        check("arst_busy", out_flush_busy, 1'b0);
        check("arst_ready", out_rob_commit_ready, 1'b0);
        sb.delete();
        #1 rst = 1'b1;
        step();
        check("after_arst_reg", out_reg_commit_reg, 5'd0);
        check("after_arst_ready", out_rob_commit_ready, 1'b1);
        check("after_arst_count", out_queue_count, 3'd0);

        // Continuous dual retire: backpressure at count 3, wrap, strict order.
        begin
            int n;
            int exp_cnt;
            int pushes;
            logic exp_rdy;
            n = 0;
            exp_cnt = 0;
            for (int cyc = 0; cyc < 60 && n < 20; cyc++) begin
                drive(2'b11, 5'(n + 1), 5'(n + 2), 1'b0);
                in_rob_commit_value0 = $urandom;
                in_rob_commit_value1 = $urandom;
                in_rob_commit_rob0   = 4'(n + 1);
                in_rob_commit_rob1   = 4'(n + 2);
                exp_rdy = (exp_cnt <= 2);
                check($sformatf("tput%0d_ready", cyc), out_rob_commit_ready, exp_rdy);
                step();
                pushes = exp_rdy ? 2 : 0;
                if (exp_rdy) n += 2;
                exp_cnt = exp_cnt + pushes - ((exp_cnt > 0) ? 1 : 0);
                check($sformatf("tput%0d_count", cyc), out_queue_count, 3'(exp_cnt));
            end
            check("tput_all_sent", (n >= 20), 1'b1);
            drive(2'b00, 5'd0, 5'd0, 1'b0);
            for (int k = 0; k < 12 && sb.size() > 0; k++) step();
            step();
            check("tput_drained", sb.size(), 0);
            check("tput_count_zero", out_queue_count, 3'd0);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
